// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified instruction/data memory arbiter:
//   - default address/data widths
//   - all-ones byte-enable constant used for instruction fetches
//   - arbiter FSM state encoding
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    // Fetches always read a full word.
    localparam logic [BE_W_DEF-1:0] BE_ALL = {BE_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } arb_state_e;

endpackage

// File: rtl/grant_phase.sv
// ----------------------------------------------------------------------------
// grant_phase
// Single priority flop for the memory arbiter. After a grant completes it
// remembers who was just served so the other side wins the next contention.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset (phase -> 0, data preferred)
//   done     - a grant completes this cycle
//   served_d - the completing grant belonged to the data side
//   phase    - 0 = data preferred, 1 = fetch preferred
// ----------------------------------------------------------------------------
module grant_phase
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic done,
    input  logic served_d,
    output logic phase
);

    logic phase_r;

    // Priority bit: flips preference toward whoever was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= 1'b0;
        end else if (done) begin
            phase_r <= served_d;
        end else begin
            phase_r <= phase_r;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port memory between the instruction-fetch stage and the
// load/store stage. One requester is granted at a time; under contention the
// grant alternates (data, fetch, data, ...). The memory request is
// registered and held constant until the memory signals mem_ready, after
// which the winner gets a one-cycle valid pulse with its read data.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   if_req/if_addr                - fetch request and address
//   if_rdata/if_valid             - fetched word and completion pulse
//   d_req/d_we/d_be/d_addr/d_wdata- data request (load or store)
//   d_rdata/d_valid               - load data and completion pulse
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata            - registered memory request
//   mem_ready/mem_rdata           - memory completion and read data
//   stall                         - some request is still unserved
//   phase                         - 0 = data preferred, 1 = fetch preferred
// ----------------------------------------------------------------------------
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall,
    output logic                phase
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] FETCH_BE =
        (BE_W == BE_W_DEF) ? BE_W'(BE_ALL) : {BE_W{1'b1}};

    arb_state_e          state_r;
    arb_state_e          state_next_s;

    logic                mem_req_r;
    logic                mem_we_r;
    logic [BE_W-1:0]     mem_be_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   d_rdata_r;
    logic                if_valid_r;
    logic                d_valid_r;

    logic                fetch_pend_s;
    logic                data_pend_s;
    logic                win_i_s;
    logic                win_d_s;
    logic                load_i_s;
    logic                load_d_s;
    logic                done_i_s;
    logic                done_d_s;
    logic                phase_s;

    // A requester whose valid is pulsing still holds req for this cycle;
    // masking it stops the same request from being issued twice.
    assign fetch_pend_s = if_req & ~if_valid_r;
    assign data_pend_s  = d_req  & ~d_valid_r;

    // Contention is settled by the phase bit; otherwise the lone requester wins.
    assign win_i_s = fetch_pend_s & (~data_pend_s | phase_s);
    assign win_d_s = data_pend_s  & (~fetch_pend_s | ~phase_s);

    // Next-state and grant/completion strobes.
    always_comb begin
        state_next_s = state_r;
        load_i_s     = 1'b0;
        load_d_s     = 1'b0;
        done_i_s     = 1'b0;
        done_d_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_i_s) begin
                    state_next_s = GRANT_I;
                    load_i_s     = 1'b1;
                end else if (win_d_s) begin
                    state_next_s = GRANT_D;
                    load_d_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT_I: begin
                if (mem_ready) begin
                    state_next_s = IDLE;
                    done_i_s     = 1'b1;
                end else begin
                    state_next_s = GRANT_I;
                end
            end
            GRANT_D: begin
                if (mem_ready) begin
                    state_next_s = IDLE;
                    done_d_s     = 1'b1;
                end else begin
                    state_next_s = GRANT_D;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory request registers: loaded on grant, held until completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= {BE_W{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (load_i_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_be_r    <= FETCH_BE;
            mem_addr_r  <= if_addr;
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (load_d_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= d_we;
            mem_be_r    <= d_be;
            mem_addr_r  <= d_addr;
            mem_wdata_r <= d_wdata;
        end else if (done_i_s || done_d_s) begin
            mem_req_r   <= 1'b0;
        end else begin
            mem_req_r   <= mem_req_r;
        end
    end

    // Completion pulses and read-data capture; stores leave d_rdata alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_r <= 1'b0;
            d_valid_r  <= 1'b0;
            if_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            if_valid_r <= done_i_s;
            d_valid_r  <= done_d_s;
            if (done_i_s) begin
                if_rdata_r <= mem_rdata;
            end
            if (done_d_s && !mem_we_r) begin
                d_rdata_r <= mem_rdata;
            end
        end
    end

    grant_phase u_grant_phase (
        .clk      (clk),
        .rst      (rst),
        .done     (done_i_s | done_d_s),
        .served_d (done_d_s),
        .phase    (phase_s)
    );

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_be    = mem_be_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign if_valid  = if_valid_r;
    assign d_rdata   = d_rdata_r;
    assign d_valid   = d_valid_r;
    assign phase     = phase_s;

    // Stall is combinational so the pipeline freezes in the request cycle.
    assign stall = (if_req & ~if_valid_r) | (d_req & ~d_valid_r);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Directed bench with a scoreboard: requester tasks push the expected
// transaction into per-side queues, and a monitor pops and compares on each
// valid pulse. A grant-order queue checks the alternation. A small memory
// responder answers mem_req after a programmable delay from a preloaded image.
// ----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        phase;

    always #5 clk = ~clk;

    unified_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .phase     (phase)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          len;
    } exp_t;

    exp_t exp_i[$];
    exp_t exp_d[$];
    bit   exp_order[$];   // 1 = fetch grant, 0 = data grant

    // ---------------- memory responder ----------------
    logic [31:0] mem_img [logic [31:0]];
    int          mem_delay = 0;
    int          wait_cnt  = 0;

    function automatic logic [31:0] img(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return 32'h0;
    endfunction

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1) begin
                if (wait_cnt == mem_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = img(mem_addr);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hXXXX_XXXX;
                end
                wait_cnt++;
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          mon_cyc  = 0;
    int          rise_cyc = 0;
    int          dval_cyc = 0;
    int          run_len  = 0;
    int          last_len = 0;
    logic        prev_req = 1'b0;
    logic        prev_iv  = 1'b0;
    logic        prev_dv  = 1'b0;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    task automatic score(input string side, input exp_t e, input logic [31:0] rdata,
                         input logic prev_v, input bit is_i);
        bit o;
        chk({side, "_addr"}, cap_addr, e.addr);
        chk({side, "_we_be"}, {27'd0, cap_we, cap_be}, {27'd0, e.we, e.be});
        if (e.we) chk({side, "_wdata"}, cap_wdata, e.wdata);
        chk({side, "_rdata"}, rdata, e.rdata);
        chk({side, "_req_len"}, 32'(last_len), 32'(e.len));
        chk({side, "_valid_pulse"}, 32'(prev_v), 32'd0);
        if (exp_order.size() > 0) begin
            o = exp_order.pop_front();
            chk("grant_order", 32'(is_i), 32'(o));
        end else begin
            chk("grant_order_extra", 32'(is_i), 32'd2);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (mem_req === 1'b1) begin
                if (!prev_req) begin
                    cap_we    = mem_we;
                    cap_be    = mem_be;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    run_len   = 1;
                    rise_cyc  = mon_cyc;
                end else begin
                    run_len++;
                    chk("mem_hold_addr", mem_addr, cap_addr);
                    chk("mem_hold_ctl", {27'd0, mem_we, mem_be}, {27'd0, cap_we, cap_be});
                end
            end else if (prev_req) begin
                last_len = run_len;
            end
            prev_req = (mem_req === 1'b1);
            if (if_valid === 1'b1) begin
                if (exp_i.size() > 0) score("if", exp_i.pop_front(), if_rdata, prev_iv, 1'b1);
                else chk("if_valid_spurious", 32'(if_valid), 32'd0);
            end
            if (d_valid === 1'b1) begin
                dval_cyc = mon_cyc;
                if (exp_d.size() > 0) score("d", exp_d.pop_front(), d_rdata, prev_dv, 1'b0);
                else chk("d_valid_spurious", 32'(d_valid), 32'd0);
            end
            prev_iv = (if_valid === 1'b1);
            prev_dv = (d_valid === 1'b1);
        end
    end

    // ---------------- requester tasks ----------------
    task automatic fetch(input logic [31:0] a, input logic [31:0] rd, input int len);
        exp_t e;
        bit   got;
        e.we = 1'b0; e.be = 4'hF; e.addr = a; e.wdata = 32'h0; e.rdata = rd; e.len = len;
        exp_i.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
        got     = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk);
            #1;
            if (if_valid === 1'b1) got = 1'b1;
        end
        chk("fetch_done", 32'(got), 32'd1);
        if_req = 1'b0;
    endtask

    task automatic data_xfer(input logic we, input logic [3:0] be, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int len);
        exp_t e;
        bit   got;
        e.we = we; e.be = be; e.addr = a; e.wdata = wd; e.rdata = rd; e.len = len;
        exp_d.push_back(e);
        d_we    = we;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        got     = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk);
            #1;
            if (d_valid === 1'b1) got = 1'b1;
        end
        chk("data_done", 32'(got), 32'd1);
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        bit   seen;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

        mem_img[32'h0000_0010] = 32'h0000_0093;
        mem_img[32'h0000_0100] = 32'hDEAD_BEEF;
        mem_img[32'h0000_0040] = 32'h0000_0513;
        mem_img[32'h0000_0020] = 32'h00A0_0113;
        mem_img[32'h0000_0024] = 32'h0000_0042;
        mem_img[32'h0000_0080] = 32'h0000_0055;
        for (int k = 0; k < 4; k++) begin
            mem_img[32'h0000_0200 + 32'(4 * k)] = 32'h1000_0000 + 32'(k);
            mem_img[32'h0000_0300 + 32'(4 * k)] = 32'h2000_0000 + 32'(k);
        end

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        // Fetch-only, minimum latency
        mem_delay = 0;
        exp_order.push_back(1'b1);
        fork
            fetch(32'h0000_0010, 32'h0000_0093, 1);
            begin
                @(negedge clk);
                chk("f1_c0_stall", 32'(stall), 32'd1);
                chk("f1_c0_mem_req", 32'(mem_req), 32'd0);
                @(negedge clk);
                chk("f1_c1_mem_req", 32'(mem_req), 32'd1);
                chk("f1_c1_stall", 32'(stall), 32'd1);
                @(negedge clk);
                chk("f1_c2_if_valid", 32'(if_valid), 32'd1);
            end
        join
        chk("f1_phase", 32'(phase), 32'd0);

        // Load with a 3-cycle memory delay
        mem_delay = 3;
        exp_order.push_back(1'b0);
        data_xfer(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 4);
        chk("ld_phase", 32'(phase), 32'd1);

        // Reset while a fetch grant waits on memory
        mem_delay = 100;
        e.we = 1'b0; e.be = 4'hF; e.addr = 32'h0000_0040; e.wdata = 32'h0;
        e.rdata = 32'h0000_0513; e.len = 1;
        exp_i.push_back(e);
        exp_order.push_back(1'b1);
        if_addr = 32'h0000_0040;
        if_req  = 1'b1;
        seen    = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (mem_req === 1'b1) seen = 1'b1;
        end
        chk("rstg_granted", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_delay = 0;
        @(negedge clk);
        chk("rstg_mem_req", 32'(mem_req), 32'd0);
        chk("rstg_phase", 32'(phase), 32'd0);
        chk("rstg_if_valid", 32'(if_valid), 32'd0);
        chk("rstg_stall", 32'(stall), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (if_valid === 1'b1) seen = 1'b1;
        end
        chk("rstg_reissue_done", 32'(seen), 32'd1);
        if_req = 1'b0;

        // Simultaneous requests from reset: data first, then fetch
        do_reset();
        exp_order.push_back(1'b0);
        exp_order.push_back(1'b1);
        fork
            fetch(32'h0000_0020, 32'h00A0_0113, 1);
            data_xfer(1'b0, 4'hF, 32'h0000_0024, 32'h0, 32'h0000_0042, 1);
        join
        chk("sim_phase", 32'(phase), 32'd0);
        chk("sim_i_after_dvalid", 32'(rise_cyc - dval_cyc), 32'd1);

        // Continuous contention: strict D,I alternation
        for (int k = 0; k < 4; k++) begin
            exp_order.push_back(1'b0);
            exp_order.push_back(1'b1);
        end
        fork
            for (int k = 0; k < 4; k++)
                fetch(32'h0000_0200 + 32'(4 * k), 32'h1000_0000 + 32'(k), 1);
            for (int j = 0; j < 4; j++)
                data_xfer(1'b0, 4'hF, 32'h0000_0300 + 32'(4 * j), 32'h0,
                          32'h2000_0000 + 32'(j), 1);
        join

        // Stores leave d_rdata unchanged, including an all-zero byte enable
        exp_order.push_back(1'b0);
        exp_order.push_back(1'b0);
        exp_order.push_back(1'b0);
        data_xfer(1'b0, 4'hF, 32'h0000_0080, 32'h0, 32'h0000_0055, 1);
        data_xfer(1'b1, 4'b0011, 32'h0000_0084, 32'h1234_ABCD, 32'h0000_0055, 1);
        data_xfer(1'b1, 4'b0000, 32'h0000_0088, 32'hCAFE_F00D, 32'h0000_0055, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("end_exp_i_empty", 32'(exp_i.size()), 32'd0);
        chk("end_exp_d_empty", 32'(exp_d.size()), 32'd0);
        chk("end_order_empty", 32'(exp_order.size()), 32'd0);
        chk("end_stall", 32'(stall), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined RISC-V core.
- Grants one requester at a time and alternates priority under contention.
- Holds the memory request stable until the memory handshakes it.
- Drives the pipeline-wide stall while any request is unserved.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
if_req  input  1  fetch request, held high until if_valid
if_addr  input  ADDR_W  fetch address, stable while if_req
if_rdata  output  DATA_W  fetched instruction, valid when if_valid
if_valid  output  1  one-cycle completion pulse for fetch
d_req  input  1  data request, held high until d_valid
d_we  input  1  1 = store, 0 = load
d_be  input  DATA_W/8  store byte enables
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_rdata  output  DATA_W  load data, valid when d_valid
d_valid  output  1  one-cycle completion pulse for data
mem_req  output  1  memory request, registered
mem_we  output  1  registered write enable
mem_be  output  DATA_W/8  registered byte enables (all ones for fetch)
mem_addr  output  ADDR_W  registered address
mem_wdata  output  DATA_W  registered write data
mem_ready  input  1  memory accepts/completes the current request this cycle
mem_rdata  input  DATA_W  read data, valid with mem_ready
stall  output  1  pipeline stall
phase  output  1  current priority bit: 0 = data preferred, 1 = fetch preferred

Behaviour:
- Clocking: clk, synchronous active-high rst.
- Reset values (applied at the edge where rst=1, regardless of state):
  - state=IDLE, phase=0.
  - mem_req/mem_we=0; mem_be/mem_addr/mem_wdata=0.
  - if_valid/d_valid=0; if_rdata/d_rdata=0.
- An in-flight memory transaction is abandoned on reset. The memory must tolerate mem_req dropping.
- FSM states: IDLE (2'b00), GRANT_I (2'b01), GRANT_D (2'b10).
- IDLE:
  - mem_ready is ignored.
  - A requester whose valid is high this cycle is masked. This prevents re-issue before it drops req.
  - Only if_req → GRANT_I. Only d_req → GRANT_D.
  - Both requests → GRANT_D if phase=0, else GRANT_I.
  - On entry to a grant state, the mem_* registers load the winner's signals at the same edge. Fetch loads mem_we=0 and mem_be=all ones.
- GRANT_x:
  - mem_req=1; mem_* are held constant.
  - mem_ready=0 → stay.
  - mem_ready=1 → next edge: state=IDLE, mem_req=0, x_valid=1 for exactly one cycle.
  - Loads and fetches capture mem_rdata into x_rdata at that edge. Stores leave d_rdata unchanged.
  - phase is set to 1 after a data grant completes and to 0 after a fetch grant completes.
- Minimum latency: req high in IDLE (cycle 0) → mem_req cycle 1 → valid cycle 2, with mem_ready=1 in cycle 1.
- A losing requester waits at least until the winner's valid cycle plus one.
- stall = (if_req & ~if_valid) | (d_req & ~d_valid), combinational.
- Requester drops req while granted: the transaction still completes and valid still pulses. Requesters must tolerate this.
- d_be=0 store: issued normally with mem_be=0.
- Back-to-back contention strictly alternates D, I, D, I…; neither side starves.

Decomposition:
- Package mem_arb_pkg:
  - FSM state encodings IDLE/GRANT_I/GRANT_D.
  - Default ADDR_W/DATA_W.
  - Constant BE_ALL for fetch byte enables.
- Sub-module: grant_phase, the single priority flop.
  - Inputs: clk, rst, done, served_d. Output: phase.
  - Reset value 0; loads served_d on done.

Test Plan:
- Fetch-only, if_req=1, if_addr=0x0000_0010, mem_ready=1 on first mem_req cycle, mem_rdata=0x0000_0093 → mem_addr=0x10, mem_we=0, mem_be=4'hF in cycle 1; if_valid=1 with if_rdata=0x93 in cycle 2; stall high cycles 0–1.
- Load with mem_ready delayed 3 cycles, d_addr=0x100, mem_rdata=0xDEADBEEF → mem_req high 4 cycles with constant mem_addr; d_valid single pulse with d_rdata=0xDEADBEEF; phase=1 afterwards.
- Simultaneous if_req and d_req from reset (phase=0) → GRANT_D first. Then GRANT_I, starting the cycle after d_valid. if_valid comes last; phase ends 0.
- Continuous contention with 8 transactions, d_req/if_req re-raised immediately → grant order D,I,D,I,D,I,D,I.
- Store d_we=1, d_be=4'b0011, d_wdata=0x1234ABCD, d_rdata previously 0x55 → mem_we=1, mem_be=4'b0011, mem_wdata=0x1234ABCD; d_valid pulses; d_rdata stays 0x55.
- rst=1 while in GRANT_I with mem_ready low → next edge: mem_req=0, state IDLE, phase=0, no if_valid pulse. After rst drops, a held if_req is re-issued from scratch.
